// File: rtl/input_line_buffer_ctrl_if.sv
// Handshake and datapath-control bundle for input_line_buffer_ctrl.
// stall_cycles is present only when ILB_CTRL_STALL_CNT_EN is defined.
interface input_line_buffer_ctrl_if;
    logic       start;
    logic [7:0] img_size;
    logic       in_valid;
    logic       in_ready;
    logic       out_ready;
    logic       win_valid;
    logic       busy;
    logic       done;
    logic       Wr_window;
    logic       Shift_window;
    logic       Rst_window;
    logic       window_row_n_mux;
    logic       window_row_n_1_mux;
    logic       window_row_n_2_mux;
    logic       ena_linebuff_BRAM;
    logic       wea_linebuff_BRAM;
    logic       enb_linebuff_BRAM;
    logic       en_linebuff_BRAM_counter;
    logic       rst_linebuff_BRAM_counter;
`ifdef ILB_CTRL_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    modport master (
        input  start, img_size, in_valid, out_ready,
        output in_ready, win_valid, busy, done, Wr_window, Shift_window, Rst_window,
               window_row_n_mux, window_row_n_1_mux, window_row_n_2_mux,
               ena_linebuff_BRAM, wea_linebuff_BRAM, enb_linebuff_BRAM,
               en_linebuff_BRAM_counter, rst_linebuff_BRAM_counter
`ifdef ILB_CTRL_STALL_CNT_EN
        , output stall_cycles
`endif
    );

    modport slave (
        output start, img_size, in_valid, out_ready,
        input  in_ready, win_valid, busy, done, Wr_window, Shift_window, Rst_window,
               window_row_n_mux, window_row_n_1_mux, window_row_n_2_mux,
               ena_linebuff_BRAM, wea_linebuff_BRAM, enb_linebuff_BRAM,
               en_linebuff_BRAM_counter, rst_linebuff_BRAM_counter
`ifdef ILB_CTRL_STALL_CNT_EN
        , input stall_cycles
`endif
    );
endinterface

// File: rtl/input_line_buffer_ctrl.sv
// Sequences a zero-padded 3x3 sliding window over an N x N raster stream via a two-row
// line buffer. Optional stall/starvation counter: define ILB_CTRL_STALL_CNT_EN.
module input_line_buffer_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_SIZE   = 128
) (
    input logic                      clk,
    input logic                      rst_n,
    input_line_buffer_ctrl_if.master bus_io
);

    localparam logic [7:0] MaxN = 8'(MAX_SIZE);

    // y runs to N+1 in 8 bits, so N must stay below 255.
    if (DATA_WIDTH == 0 || MAX_SIZE < 2 || MAX_SIZE > 254) begin : g_bad_param
    end

    typedef enum logic [2:0] {StIdle, StRowStart, StShift, StDrain, StDone} state_e;

    state_e     state_q, state_d;
    logic [7:0] x_q, x_d, y_q, y_d, n_q, n_d;
    logic       win_valid_q, win_valid_d;
    logic       stall, shift, pad_col, real_px, pad_row;

    assign stall   = win_valid_q && !bus_io.out_ready;
    assign pad_col = (x_q == n_q);
    assign real_px = !pad_col && (y_q < n_q);
    assign pad_row = !pad_col && (y_q == n_q);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        n_d     = n_q;
        shift   = 1'b0;
        bus_io.in_ready                  = 1'b0;
        bus_io.done                      = 1'b0;
        bus_io.Rst_window                = 1'b0;
        bus_io.rst_linebuff_BRAM_counter = 1'b0;
        bus_io.window_row_n_mux          = 1'b0;
        bus_io.window_row_n_1_mux        = 1'b0;
        bus_io.window_row_n_2_mux        = 1'b0;
        bus_io.ena_linebuff_BRAM         = 1'b0;
        bus_io.wea_linebuff_BRAM         = 1'b0;
        bus_io.enb_linebuff_BRAM         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    if (bus_io.img_size < 8'd2)      n_d = 8'd2;
                    else if (bus_io.img_size > MaxN) n_d = MaxN;
                    else                             n_d = bus_io.img_size;
                    y_d     = 8'd0;
                    state_d = StRowStart;
                end
            end
            StRowStart: begin
                // Hold off clearing the window until a pending window has been taken.
                if (!stall) begin
                    bus_io.Rst_window                = 1'b1;
                    bus_io.rst_linebuff_BRAM_counter = 1'b1;
                    x_d     = 8'd0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (real_px) begin
                    bus_io.in_ready = !stall;
                    shift           = bus_io.in_valid && !stall;
                    if (shift) begin
                        bus_io.window_row_n_mux   = 1'b1;
                        bus_io.window_row_n_1_mux = (y_q != 8'd0);
                        bus_io.window_row_n_2_mux = (y_q > 8'd1);
                        bus_io.ena_linebuff_BRAM  = 1'b1;
                        bus_io.wea_linebuff_BRAM  = 1'b1;
                        bus_io.enb_linebuff_BRAM  = 1'b1;
                    end
                end else if (pad_row) begin
                    shift = !stall;
                    if (shift) begin
                        bus_io.window_row_n_1_mux = 1'b1;
                        bus_io.window_row_n_2_mux = 1'b1;
                        bus_io.enb_linebuff_BRAM  = 1'b1;
                    end
                end else begin
                    shift = !stall;
                    if (shift) begin
                        y_d     = y_q + 8'd1;
                        state_d = (y_q < n_q) ? StRowStart : StDrain;
                    end
                end
            end
            StDrain: begin
                if (!win_valid_q || bus_io.out_ready) state_d = StDone;
            end
            StDone: begin
                bus_io.done = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase

        bus_io.Shift_window             = shift;
        bus_io.Wr_window                = shift;
        bus_io.en_linebuff_BRAM_counter = shift;
        if (shift) x_d = x_q + 8'd1;

        if (shift && (x_q != 8'd0) && (y_q != 8'd0)) win_valid_d = 1'b1;
        else if (bus_io.out_ready)                   win_valid_d = 1'b0;
        else                                         win_valid_d = win_valid_q;
    end

    assign bus_io.busy      = (state_q != StIdle);
    assign bus_io.win_valid = win_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            x_q         <= 8'd0;
            y_q         <= 8'd0;
            n_q         <= 8'd0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            n_q         <= n_d;
            win_valid_q <= win_valid_d;
        end
    end

`ifdef ILB_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        starved;

    assign starved = (state_q == StShift) && real_px && !bus_io.in_valid;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == StIdle && bus_io.start) begin
            stall_cnt_d = 16'd0;
        end else if (((state_q != StIdle) && stall || starved) && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= 16'd0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign bus_io.stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_input_line_buffer_ctrl.sv
// Self-checking bench: drives frames through the controller, models the external window and
// line-buffer datapath, and compares every emitted window with a zero-padded image reference.
module tb_input_line_buffer_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    input_line_buffer_ctrl_if bus ();

    input_line_buffer_ctrl #(
        .DATA_WIDTH(16),
        .MAX_SIZE  (128)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    typedef struct {
        int size;
        int vm;     // 0: valid always, 1: toggling, 2: random (+ spurious starts)
        int rm;     // 0: ready always, 1: random, 2: 5-cycle stall at window 2
        int exp_n;  // expected latched N
    } vec_t;

    int errors = 0;
    int checks = 0;

    bit [15:0] img [0:16383];
    bit [15:0] lb1 [0:255];
    bit [15:0] lb2 [0:255];
    bit [15:0] w   [0:2][0:2];
    bit [7:0]  addr;
    bit [15:0] cur_pix;

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] outs();
        return {bus.in_ready, bus.win_valid, bus.busy, bus.done, bus.Wr_window,
                bus.Shift_window, bus.Rst_window, bus.window_row_n_mux, bus.window_row_n_1_mux,
                bus.window_row_n_2_mux, bus.ena_linebuff_BRAM, bus.wea_linebuff_BRAM,
                bus.enb_linebuff_BRAM, bus.en_linebuff_BRAM_counter,
                bus.rst_linebuff_BRAM_counter};
    endfunction

    function automatic int clamp_ref(input int s);
        return (s < 2) ? 2 : (s > 128) ? 128 : s;
    endfunction

    function automatic logic [143:0] win_act();
        logic [143:0] v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) v = {v[127:0], w[r][c]};
        return v;
    endfunction

    // Window k has centre (k/n, k%n); out-of-image taps are zero.
    function automatic logic [143:0] win_exp(input int k, input int n);
        logic [143:0] v = '0;
        int py, px;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                py = k / n - 1 + r;
                px = k % n - 1 + c;
                v  = {v[127:0], (py >= 0 && py < n && px >= 0 && px < n) ? img[py*n+px] : 16'd0};
            end
        end
        return v;
    endfunction

    task automatic run_frame(input int size, input int vm, input int rm, input int n,
                             input int abort_at, output bit aborted);
        int cyc, budget, acc, cons, shifts, viol, ndone, done_cyc, last_cons, stall_left;
        bit stall_used, prev_stall, hs, got_done;
        bit [15:0] col [0:2];
        acc = 0; cons = 0; shifts = 0; viol = 0; ndone = 0; stall_left = 0;
        done_cyc = -1000; last_cons = 0; stall_used = 0; prev_stall = 0; got_done = 0;
        aborted = 0; cyc = 0; addr = 8'd0; cur_pix = 16'($urandom);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) w[r][c] = 16'd0;
        budget = 40 * (n + 1) * (n + 1) + 100;
        while (!got_done && cyc < budget) begin
            @(negedge clk);
            bus.img_size = 8'(size);
            bus.start    = (cyc == 0) || (vm == 2 && $urandom_range(0, 15) == 0);
            bus.in_valid = (vm == 0) ? 1'b1 : (vm == 1) ? cyc[0] : ($urandom_range(0, 3) != 0);
            if (rm == 2 && !stall_used && bus.win_valid && cons == 2) begin
                stall_left = 5;
                stall_used = 1;
            end
            if (stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = (rm == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            #1;
            if (bus.done) begin
                ndone++;
                done_cyc = cyc;
                got_done = 1;
            end
            hs = bus.in_valid && bus.in_ready;
            if (bus.win_valid && !bus.out_ready && (bus.in_ready || bus.Shift_window)) viol++;
            if (prev_stall && !bus.win_valid) viol++;
            if (bus.Wr_window != bus.Shift_window) viol++;
            if (bus.en_linebuff_BRAM_counter != bus.Shift_window) viol++;
            if (bus.Shift_window && bus.window_row_n_mux && !hs) viol++;
            if (hs && !bus.Shift_window) viol++;
            if (bus.wea_linebuff_BRAM && !bus.ena_linebuff_BRAM) viol++;
            if (bus.Shift_window && (bus.window_row_n_1_mux || bus.window_row_n_2_mux)
                && !bus.enb_linebuff_BRAM) viol++;
            if (!bus.busy && outs() != 15'd0) viol++;
            if (bus.win_valid && bus.out_ready) begin
                chk($sformatf("window_%0d_%0d", cons / n, cons % n), win_act(), win_exp(cons, n));
                cons++;
                last_cons = cyc;
            end
            if (bus.Shift_window) shifts++;
            if (hs) begin
                if (acc < 16384) img[acc] = cur_pix;
                acc++;
            end
            // Datapath update at the coming rising edge.
            if (bus.rst_linebuff_BRAM_counter) addr = 8'd0;
            if (bus.Shift_window) begin
                col[0] = bus.window_row_n_2_mux ? lb2[addr] : 16'd0;
                col[1] = bus.window_row_n_1_mux ? lb1[addr] : 16'd0;
                col[2] = bus.window_row_n_mux ? cur_pix : 16'd0;
                for (int r = 0; r < 3; r++) begin
                    w[r][0] = w[r][1];
                    w[r][1] = w[r][2];
                    w[r][2] = col[r];
                end
            end
            if (bus.wea_linebuff_BRAM) begin
                lb2[addr] = lb1[addr];
                lb1[addr] = cur_pix;
            end
            if (bus.en_linebuff_BRAM_counter) addr = addr + 8'd1;
            if (bus.Rst_window)
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) w[r][c] = 16'd0;
            if (hs) cur_pix = 16'($urandom);
            prev_stall = bus.win_valid && !bus.out_ready;
            if (abort_at > 0 && acc >= abort_at) begin
                aborted = 1;
                break;
            end
            cyc++;
        end
        bus.start = 1'b0;
        if (!aborted) begin
            chk($sformatf("windows_n%0d", n), cons, n * n);
            chk($sformatf("pixels_n%0d", n), acc, n * n);
            chk($sformatf("shifts_n%0d", n), shifts, (n + 1) * (n + 1));
            chk($sformatf("done_seen_n%0d", n), ndone, 1);
            chk($sformatf("done_latency_n%0d", n), done_cyc - last_cons, 1);
            chk($sformatf("rule_violations_n%0d", n), viol, 0);
            @(negedge clk);
            #1;
            chk("idle_after_done", outs(), 15'd0);
        end
    endtask

    vec_t vecs [0:6];
    bit   ab;
    int   nd, sz;

    initial begin
        vecs[0] = '{3,   0, 0, 3};
        vecs[1] = '{4,   0, 2, 4};
        vecs[2] = '{4,   1, 0, 4};
        vecs[3] = '{200, 0, 0, 128};
        vecs[4] = '{1,   0, 0, 2};
        vecs[5] = '{0,   2, 1, 2};
        vecs[6] = '{6,   2, 1, 6};

        bus.start = 1'b0; bus.img_size = 8'd0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        #1;
        chk("reset_outputs", outs(), 15'd0);
`ifdef ILB_CTRL_STALL_CNT_EN
        chk("reset_stall_cycles", bus.stall_cycles, 16'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].size, vecs[i].vm, vecs[i].rm, vecs[i].exp_n, 0, ab);
`ifdef ILB_CTRL_STALL_CNT_EN
            if (vecs[i].rm == 2) chk("stall_cycles", bus.stall_cycles, 16'd5);
`endif
        end

        for (int i = 0; i < 4; i++) begin
            sz = $urandom_range(0, 10);
            run_frame(sz, 2, 1, clamp_ref(sz), 0, ab);
        end

        // Reset at the first pixel of row 2, then a clean frame.
        run_frame(4, 0, 0, 4, 9, ab);
        chk("abort_reached", ab, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_outputs", outs(), 15'd0);
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (bus.done || bus.busy) nd++;
        end
        chk("no_done_in_reset", nd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(4, 2, 1, 4, 0, ab);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
